// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolution path.
package branch_resolver_pkg;

  localparam int BR_ADDR_W   = 32;
  localparam int BR_DEPTH    = 4;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [BR_ADDR_W-1:0] pc;
    logic [BR_ADDR_W-1:0] npc;
    logic                 taken;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolver_fifo.sv
// In-order queue of outstanding predictions; push, pop and clear with head/count visibility.
module resolve_fifo
  import branch_resolver_pkg::*;
#(
  parameter  int DEPTH = BR_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  pred_entry_t   push_data,
  input  logic          pop,
  input  logic          clear,
  output pred_entry_t   head,
  output logic [CW-1:0] count
);

  pred_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      // Equalise pointers instead of zeroing so storage indices stay untouched
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Checks the oldest recorded prediction against execute, trains the predictor and redirects fetch on a miss.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter  int DEPTH  = BR_DEPTH,
  parameter  int ADDR_W = BR_ADDR_W,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_pc,
  input  logic [ADDR_W-1:0] pred_npc,
  input  logic              pred_taken,
  output logic              pred_ready,
  input  logic              ex_valid,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ext_flush,
  output logic [ADDR_W-1:0] branch_pc,
  output logic [ADDR_W-1:0] branch_npc,
  output logic              actual_result,
  output logic              predict_update,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [CW-1:0]     pending,
  output logic [15:0]       mispredict_cnt
);

  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(INSTR_BYTES);

  pred_entry_t       push_entry, head;
  logic [CW-1:0]     count;
  logic              resolve, miss, train;
  logic              fifo_push, fifo_pop, fifo_clear;
  logic [ADDR_W-1:0] actual;
  logic              unused_head_taken;

  logic [ADDR_W-1:0] branch_pc_q, branch_pc_d;
  logic [ADDR_W-1:0] branch_npc_q, branch_npc_d;
  logic              actual_result_q, actual_result_d;
  logic              predict_update_q, predict_update_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;
  logic [15:0]       mispredict_cnt_q, mispredict_cnt_d;

  assign push_entry        = '{pc: pred_pc, npc: pred_npc, taken: pred_taken};
  assign unused_head_taken = head.taken;

  // Ready ignores a same-cycle pop so a full queue never accepts a push
  assign pred_ready = (count < DEPTH_C) && !flush_q;

  always_comb begin
    resolve    = ex_valid && (count != '0);
    actual     = ex_taken ? ex_target : head.pc + STEP_C;
    miss       = (actual != head.npc);
    train      = resolve && !ext_flush;
    fifo_pop   = train;
    fifo_clear = ext_flush || (train && miss);
    fifo_push  = pred_valid && pred_ready && !fifo_clear;
  end

  always_comb begin
    branch_pc_d      = branch_pc_q;
    branch_npc_d     = branch_npc_q;
    actual_result_d  = actual_result_q;
    flush_pc_d       = flush_pc_q;
    mispredict_cnt_d = mispredict_cnt_q;
    predict_update_d = train;
    flush_d          = train && miss;
    if (train) begin
      branch_pc_d     = head.pc;
      branch_npc_d    = ex_target;
      actual_result_d = ex_taken;
    end
    if (train && miss) begin
      flush_pc_d       = actual;
      mispredict_cnt_d = mispredict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_pc_q      <= '0;
      branch_npc_q     <= '0;
      actual_result_q  <= 1'b0;
      predict_update_q <= 1'b0;
      flush_q          <= 1'b0;
      flush_pc_q       <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_pc_q      <= branch_pc_d;
      branch_npc_q     <= branch_npc_d;
      actual_result_q  <= actual_result_d;
      predict_update_q <= predict_update_d;
      flush_q          <= flush_d;
      flush_pc_q       <= flush_pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  resolve_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .head      (head),
    .count     (count)
  );

  assign branch_pc      = branch_pc_q;
  assign branch_npc     = branch_npc_q;
  assign actual_result  = actual_result_q;
  assign predict_update = predict_update_q;
  assign flush          = flush_q;
  assign flush_pc       = flush_pc_q;
  assign pending        = count;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, reset corner case and randomized run against a queue model.
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid, pred_taken, pred_ready;
  logic [31:0] pred_pc, pred_npc;
  logic        ex_valid, ex_taken, ext_flush;
  logic [31:0] ex_target;
  logic [31:0] branch_pc, branch_npc, flush_pc;
  logic        actual_result, predict_update, flush;
  logic [2:0]  pending;
  logic [15:0] mispredict_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_npc(pred_npc),
    .pred_taken(pred_taken), .pred_ready(pred_ready),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .ext_flush(ext_flush),
    .branch_pc(branch_pc), .branch_npc(branch_npc), .actual_result(actual_result),
    .predict_update(predict_update), .flush(flush), .flush_pc(flush_pc),
    .pending(pending), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of outstanding predictions
  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        taken;
  } ment_t;

  ment_t       mq[$];
  logic        m_flush;
  logic [15:0] m_cnt;
  logic        e_pu, e_fl, e_ar;
  logic [31:0] e_bpc, e_bnpc, e_fpc;

  typedef struct {
    logic pv; logic [31:0] ppc; logic [31:0] pnpc; logic ptk;
    logic ev; logic etk; logic [31:0] etgt; logic ef;
    logic pu; logic fl; logic [31:0] bpc; logic [31:0] bnpc; logic ar; logic [31:0] fpc;
    int   pend; int cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pv, logic [31:0] ppc, logic [31:0] pnpc, logic ptk,
                              logic ev, logic etk, logic [31:0] etgt, logic ef,
                              logic pu, logic fl, logic [31:0] bpc, logic [31:0] bnpc,
                              logic ar, logic [31:0] fpc, int pend, int cnt);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pnpc = pnpc; v.ptk = ptk;
    v.ev = ev; v.etk = etk; v.etgt = etgt; v.ef = ef;
    v.pu = pu; v.fl = fl; v.bpc = bpc; v.bnpc = bnpc; v.ar = ar; v.fpc = fpc;
    v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 1'b0;
    m_cnt   = '0;
  endtask

  // One clock: check ready, drive, advance model, compare outputs 1 time unit after the edge
  task automatic step(input logic pv, input logic [31:0] ppc, input logic [31:0] pnpc,
                      input logic ptk, input logic ev, input logic etk,
                      input logic [31:0] etgt, input logic ef);
    logic        ready, miss;
    logic [31:0] act;
    ment_t       h;
    ready = (mq.size() < DEPTH) && !m_flush;
    chk("pred_ready", {31'd0, pred_ready}, {31'd0, ready});
    pred_valid = pv; pred_pc = ppc; pred_npc = pnpc; pred_taken = ptk;
    ex_valid = ev; ex_taken = etk; ex_target = etgt; ext_flush = ef;
    e_pu = 1'b0; e_fl = 1'b0; miss = 1'b0;
    if (ef) begin
      mq.delete();
    end else begin
      if (ev && mq.size() > 0) begin
        h      = mq.pop_front();
        act    = etk ? etgt : h.pc + 32'd4;
        miss   = (act != h.npc);
        e_pu   = 1'b1;
        e_bpc  = h.pc;
        e_bnpc = etgt;
        e_ar   = etk;
        if (miss) begin
          e_fl  = 1'b1;
          e_fpc = act;
          m_cnt = m_cnt + 16'd1;
          mq.delete();
        end
      end
      if (pv && ready && !miss) mq.push_back('{pc: ppc, npc: pnpc, taken: ptk});
    end
    m_flush = e_fl;
    @(posedge clk);
    #1;
    chk("predict_update", {31'd0, predict_update}, {31'd0, e_pu});
    chk("flush", {31'd0, flush}, {31'd0, e_fl});
    chk("pending", {29'd0, pending}, mq.size());
    chk("mispredict_cnt", {16'd0, mispredict_cnt}, {16'd0, m_cnt});
    if (e_pu) begin
      chk("branch_pc", branch_pc, e_bpc);
      chk("branch_npc", branch_npc, e_bnpc);
      chk("actual_result", {31'd0, actual_result}, {31'd0, e_ar});
    end
    if (e_fl) chk("flush_pc", flush_pc, e_fpc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pending"}, {29'd0, pending}, 32'd0);
    chk({tag, "_ready"}, {31'd0, pred_ready}, 32'd1);
    chk({tag, "_pu"}, {31'd0, predict_update}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_flush_pc"}, flush_pc, 32'd0);
    chk({tag, "_bpc"}, branch_pc, 32'd0);
    chk({tag, "_bnpc"}, branch_npc, 32'd0);
    chk({tag, "_ar"}, {31'd0, actual_result}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, mispredict_cnt}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    logic        pv, ptk, ev, etk, ef;
    logic [31:0] ppc, pnpc, etgt;

    rst_n = 1'b0;
    pred_valid = 0; pred_pc = 0; pred_npc = 0; pred_taken = 0;
    ex_valid = 0; ex_taken = 0; ex_target = 0; ext_flush = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Correct taken
    tbl.push_back(mk(1, 'h100, 'h200, 1,  0, 0, 0, 0,      0, 0, 0, 0, 0, 0,          1, 0));
    tbl.push_back(mk(0, 0, 0, 0,          1, 1, 'h200, 0,  1, 0, 'h100, 'h200, 1, 0,  0, 0));
    // Not-taken mispredict; younger 0x200 entry never trained
    tbl.push_back(mk(1, 'h100, 'h200, 1,  0, 0, 0, 0,      0, 0, 0, 0, 0, 0,          1, 0));
    tbl.push_back(mk(1, 'h200, 'h204, 0,  0, 0, 0, 0,      0, 0, 0, 0, 0, 0,          2, 0));
    tbl.push_back(mk(0, 0, 0, 0,          1, 0, 0, 0,      1, 1, 'h100, 0, 0, 'h104,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0,          0, 0, 0, 0,      0, 0, 0, 0, 0, 0,          0, 1));
    // Wrong target
    tbl.push_back(mk(1, 'h40, 'h80, 1,    0, 0, 0, 0,      0, 0, 0, 0, 0, 0,          1, 1));
    tbl.push_back(mk(0, 0, 0, 0,          1, 1, 'h90, 0,   1, 1, 'h40, 'h90, 1, 'h90, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,          0, 0, 0, 0,      0, 0, 0, 0, 0, 0,          0, 2));
    // Fill, then resolve while a push is refused
    tbl.push_back(mk(1, 'h1000, 'h1004, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0,          1, 2));
    tbl.push_back(mk(1, 'h1010, 'h1014, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0,          2, 2));
    tbl.push_back(mk(1, 'h1020, 'h1024, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0,          3, 2));
    tbl.push_back(mk(1, 'h1030, 'h1034, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0,          4, 2));
    tbl.push_back(mk(1, 'h2000, 'h2004, 0, 1, 0, 0, 0,     1, 0, 'h1000, 0, 0, 0,     3, 2));
    tbl.push_back(mk(0, 0, 0, 0,          1, 0, 0, 0,      1, 0, 'h1010, 0, 0, 0,     2, 2));
    // ext_flush beats a mispredict
    tbl.push_back(mk(0, 0, 0, 0,          1, 1, 'h5000, 1, 0, 0, 0, 0, 0, 0,          0, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.pv, v.ppc, v.pnpc, v.ptk, v.ev, v.etk, v.etgt, v.ef);
      chk($sformatf("tbl%0d_pu", i), {31'd0, predict_update}, {31'd0, v.pu});
      chk($sformatf("tbl%0d_flush", i), {31'd0, flush}, {31'd0, v.fl});
      chk($sformatf("tbl%0d_pending", i), {29'd0, pending}, v.pend);
      chk($sformatf("tbl%0d_cnt", i), {16'd0, mispredict_cnt}, v.cnt);
      if (v.pu) begin
        chk($sformatf("tbl%0d_bpc", i), branch_pc, v.bpc);
        chk($sformatf("tbl%0d_bnpc", i), branch_npc, v.bnpc);
        chk($sformatf("tbl%0d_ar", i), {31'd0, actual_result}, {31'd0, v.ar});
      end
      if (v.fl) chk($sformatf("tbl%0d_fpc", i), flush_pc, v.fpc);
    end

    // Asynchronous reset between edges with three entries outstanding
    step(1, 'h300, 'h304, 0, 0, 0, 0, 0);
    step(1, 'h304, 'h400, 1, 0, 0, 0, 0);
    step(1, 'h400, 'h404, 0, 0, 0, 0, 0);
    chk("rst_pre_pending", {29'd0, pending}, 32'd3);
    pred_valid = 0; ex_valid = 0; ext_flush = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1, 1, 'h300, 0);
    chk("stray_ex_pu", {31'd0, predict_update}, 32'd0);

    // Randomized traffic, including address wrap at the top of memory
    for (int i = 0; i < 600; i++) begin
      pv   = ($urandom % 3) != 0;
      ppc  = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
      ptk  = $urandom % 2;
      pnpc = ptk ? ($urandom & 32'h0000_FFFC) : ppc + 32'd4;
      ev   = ($urandom % 10) < 4;
      etk  = $urandom % 2;
      etgt = $urandom & 32'h0000_FFFC;
      if (mq.size() > 0) begin
        if (($urandom % 10) < 7) etk  = mq[0].taken;
        if (($urandom % 10) < 7) etgt = mq[0].npc;
      end
      ef = ($urandom % 25) == 0;
      step(pv, ppc, pnpc, ptk, ev, etk, etgt, ef);
    end

    pred_valid = 0; ex_valid = 0; ext_flush = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution end of the branch-prediction path.
- Records each prediction issued at fetch (pc, predicted next pc, predicted direction) in an in-order queue.
- Compares the oldest recorded prediction against the outcome reported by execute, then drives the predictor training interface (branch_pc, branch_npc, actual_result, predict_update).
- On a wrong next pc, raises a one-cycle pipeline flush with the corrected fetch address and discards every younger recorded prediction.

Parameters:
- DEPTH, 4, number of in-flight predictions tracked; power of two, at least 2.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pred_valid  in  1  fetch pushes one control-flow prediction
- pred_pc  in  ADDR_W  pc of the predicted instruction
- pred_npc  in  ADDR_W  next pc chosen by fetch
- pred_taken  in  1  predicted direction
- pred_ready  out  1  queue can accept a push this cycle
- ex_valid  in  1  execute resolved the oldest outstanding control-flow instruction
- ex_taken  in  1  actual direction
- ex_target  in  ADDR_W  actual target; meaningful when ex_taken=1
- ext_flush  in  1  external flush (exception/interrupt); clears the queue and generates no training
- branch_pc  out  ADDR_W  training pc
- branch_npc  out  ADDR_W  training target (ex_target)
- actual_result  out  1  training direction
- predict_update  out  1  training strobe, one cycle per resolution
- flush  out  1  mispredict redirect strobe
- flush_pc  out  ADDR_W  corrected fetch address
- pending  out  log2(DEPTH)+1  occupancy
- mispredict_cnt  out  16  count of mispredictions, wraps at 2^16

Behaviour:
- Reset:
  - clk is the single clock; rst_n is asynchronous and active-low.
  - While reset is asserted: queue empty, head and tail pointers 0, pending=0, pred_ready=1, and all registered outputs 0 (branch_pc, branch_npc, actual_result, predict_update, flush, flush_pc, mispredict_cnt).
  - Asserting reset mid-operation discards all entries with no training and no flush.
- pred_ready:
  - Defined as (pending < DEPTH) && !flush, combinational from registered state.
  - A push happens only when pred_valid && pred_ready.
  - A push and a pop in the same cycle are both honoured; a full queue with a pop still refuses the push, because pred_ready ignores the pop.
- Resolution, in the cycle ex_valid=1 with pending>0:
  - actual = ex_taken ? ex_target : head.pc + 4, computed modulo 2^ADDR_W.
  - miss = (actual != head.npc). This also catches a taken prediction with the wrong target.
  - At the next edge, the outputs for one cycle are: predict_update=1, branch_pc=head.pc, branch_npc=ex_target, actual_result=ex_taken.
  - The head entry is popped.
- Mispredict (miss=1):
  - At the same edge: flush=1 and flush_pc=actual for one cycle; mispredict_cnt increments.
  - Every remaining entry is cleared (pointers equalised, pending=0).
  - A push offered in the resolving cycle is dropped.
  - Pushes in the cycle flush=1 are refused through pred_ready.
- ex_valid with pending=0 is a protocol violation: ignored, no training, no flush.
- ext_flush:
  - Clears the queue at the next edge.
  - Suppresses training and redirect for any ex_valid in the same cycle.
  - Drops any push in the same cycle.
  - Has priority over a mispredict.
- Latency: ex_valid to predict_update/flush is exactly 1 cycle. There is no back-pressure on execute.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by pending, not by pointer equality.

Decomposition:
- Shared package holds:
  - the entry struct {pc, npc, taken};
  - ADDR_W;
  - the default DEPTH;
  - the constant for instruction width, 4.
- One natural sub-module, resolve_fifo: a synchronous queue with push, pop and clear, exposing the head entry and the count. The compare logic, flush logic and training-register logic stay in the top level.

Test Plan:
- Correct taken: push {pc=0x100, npc=0x200, taken=1}, then ex_valid with taken=1, target=0x200 -> next cycle predict_update=1, branch_pc=0x100, branch_npc=0x200, actual_result=1, flush=0, pending=0.
- Not-taken mispredict: push {0x100, 0x200, 1} and {0x200, 0x204, 0}, then ex_valid with taken=0 -> predict_update=1, actual_result=0, flush=1, flush_pc=0x104, pending=0, mispredict_cnt=1, and the 0x200 entry is never trained.
- Wrong target: push {0x40, 0x80, 1}, then ex_valid with taken=1, target=0x90 -> flush=1, flush_pc=0x90, branch_npc=0x90.
- Full and simultaneous events: push 4 entries -> pred_ready=0. Resolve the head correctly while pushing -> push refused, pending=3, pred_ready=1 the next cycle.
- ext_flush together with ex_valid on a mispredict -> predict_update=0, flush=0, pending=0, mispredict_cnt unchanged.
- Reset mid-operation: pending=3, deassert rst_n asynchronously between edges -> outputs 0 immediately, pending=0. After release, a stray ex_valid produces no predict_update.
